// File: rtl/cacheline_burst_pkg.sv
// Shared types and elaboration helpers for the cache-line to memory-burst adaptor.
// Latency: none (compile-time definitions only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package cacheline_burst_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        GAP  = 3'd2,
        RD   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Number of memory beats that make up one cache line.
    function automatic int calc_beats(input int line_w, input int burst_w);
        return line_w / burst_w;
    endfunction

    // Number of byte-offset bits inside one cache line.
    function automatic int calc_off(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // The line must split into a power-of-two number (>= 2) of whole beats.
    function automatic bit params_ok(input int line_w, input int burst_w);
        int beats;
        if (burst_w <= 0 || (line_w % burst_w) != 0 || (line_w % 8) != 0) begin
            return 1'b0;
        end
        beats = line_w / burst_w;
        return (beats >= 2) && ((beats & (beats - 1)) == 0);
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_beat_counter.sv
// Mod-BEATS beat counter with enable, synchronous clear and last-beat flag.
// Latency: count updates one cycle after en_i; last_o is combinational from the count.
// Backpressure: holds its value while en_i is low.
`timescale 1ns/1ps
module burst_beat_counter #(
    parameter int BEATS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     clr_i,
    output logic [$clog2(BEATS)-1:0] cnt_o,
    output logic                     last_o
);

    localparam int CW = $clog2(BEATS);

    logic [CW-1:0] cnt_d, cnt_q;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Splits LLC lines into memory bursts and reassembles fills; evict-then-fill runs WB, GAP, RD.
// Latency: strobes rise the cycle after acceptance; resp_o pulses one cycle after the last beat ack.
// Backpressure: resp_i low stalls beat count, data and strobes. CACHELINE_BURST_PERF_EN adds perf counters.
`timescale 1ns/1ps
module cacheline_burst_adaptor
    import cacheline_burst_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [ADDR_W-1:0]  wb_address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic               resp_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o
`ifdef CACHELINE_BURST_PERF_EN
    ,
    output logic [31:0]        perf_fills_o,
    output logic [31:0]        perf_wbs_o,
    output logic [31:0]        perf_stall_o
`endif
);

    localparam int BEATS = calc_beats(LINE_W, BURST_W);
    localparam int OFF   = calc_off(LINE_W);
    localparam int CW    = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF;

    if (!params_ok(LINE_W, BURST_W)) begin : g_bad_params
        $error("cacheline_burst_adaptor: LINE_W/BURST_W must be a power of two >= 2");
    end

    state_t              state_d, state_q;
    logic [LINE_W-1:0]   wb_dat_d, wb_dat_q;
    logic [LINE_W-1:0]   line_d, line_q;
    logic [ADDR_W-1:0]   wr_addr_d, wr_addr_q;
    logic [ADDR_W-1:0]   fill_addr_d, fill_addr_q;
    logic [ADDR_W-1:0]   addr_d, addr_q;
    logic                fill_pend_d, fill_pend_q;
    logic                read_d, read_q;
    logic                write_d, write_q;
    logic                resp_d, resp_q;
    logic [CW-1:0]       cnt;
    logic                cnt_last;
    logic                beat_en;
    logic                beat_last;

    // A beat completes on any memory ack while a burst is in flight.
    assign beat_en   = resp_i && ((state_q == WB) || (state_q == RD));
    assign beat_last = beat_en && cnt_last;

    burst_beat_counter #(
        .BEATS (BEATS)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .en_i   (beat_en),
        .clr_i  (beat_last),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Next-state, request latching, fill assembly and registered-output decode.
    always_comb begin
        state_d     = state_q;
        wb_dat_d    = wb_dat_q;
        line_d      = line_q;
        wr_addr_d   = wr_addr_q;
        fill_addr_d = fill_addr_q;
        fill_pend_d = fill_pend_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    // Write-back first; a simultaneous read becomes the pending fill.
                    wb_dat_d    = line_i;
                    wr_addr_d   = (read_i ? wb_address_i : address_i) & ALIGN_MASK;
                    fill_pend_d = read_i;
                    if (read_i) begin
                        fill_addr_d = address_i & ALIGN_MASK;
                    end
                    state_d = WB;
                end else if (read_i) begin
                    fill_addr_d = address_i & ALIGN_MASK;
                    fill_pend_d = 1'b1;
                    state_d     = RD;
                end
            end
            WB: begin
                if (beat_last) begin
                    state_d = fill_pend_q ? GAP : DONE;
                end
            end
            GAP: state_d = RD;
            RD: begin
                if (beat_en) begin
                    line_d[cnt*BURST_W +: BURST_W] = burst_i;
                end
                if (beat_last) begin
                    fill_pend_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        write_d = (state_d == WB);
        read_d  = (state_d == RD);
        resp_d  = (state_d == DONE);
        addr_d  = write_d ? wr_addr_d : (read_d ? fill_addr_d : '0);
    end

    // FSM state, latched request and registered memory-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wb_dat_q    <= '0;
            line_q      <= '0;
            wr_addr_q   <= '0;
            fill_addr_q <= '0;
            fill_pend_q <= 1'b0;
            addr_q      <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            resp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_dat_q    <= wb_dat_d;
            line_q      <= line_d;
            wr_addr_q   <= wr_addr_d;
            fill_addr_q <= fill_addr_d;
            fill_pend_q <= fill_pend_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            resp_q      <= resp_d;
        end
    end

    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;
    assign address_o = addr_q;
    assign line_o    = line_q;
    // Write data follows the beat counter, so it holds through ack gaps.
    assign burst_o   = write_q ? wb_dat_q[cnt*BURST_W +: BURST_W] : '0;

`ifdef CACHELINE_BURST_PERF_EN
    logic [31:0] fills_d, fills_q;
    logic [31:0] wbs_d, wbs_q;
    logic [31:0] stall_d, stall_q;

    // Saturating event counters for completed fills, write-backs and stalled burst cycles.
    always_comb begin
        fills_d = fills_q;
        wbs_d   = wbs_q;
        stall_d = stall_q;
        if ((state_q == RD) && beat_last && (fills_q != 32'hFFFF_FFFF)) begin
            fills_d = fills_q + 32'd1;
        end
        if ((state_q == WB) && beat_last && (wbs_q != 32'hFFFF_FFFF)) begin
            wbs_d = wbs_q + 32'd1;
        end
        if (((state_q == WB) || (state_q == RD)) && !resp_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fills_q <= '0;
            wbs_q   <= '0;
            stall_q <= '0;
        end else begin
            fills_q <= fills_d;
            wbs_q   <= wbs_d;
            stall_q <= stall_d;
        end
    end

    assign perf_fills_o = fills_q;
    assign perf_wbs_o   = wbs_q;
    assign perf_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench for cacheline_burst_adaptor: 256/64 main instance plus a 512/64 instance.
// Latency: expectations are queued at stimulus time and checked whenever the DUT presents a beat or response.
// Backpressure: the memory model inserts a configurable number of idle cycles before every beat ack.
`timescale 1ns/1ps
module tb_cacheline_burst_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [LW-1:0] line_i, line_o;
    logic [AW-1:0] address_i, wb_address_i, address_o;
    logic          read_i, write_i, resp_o, resp_i, read_o, write_o;
    logic [BW-1:0] burst_i, burst_o;

    logic [511:0]  line_o512;
    logic [AW-1:0] address_i512, address_o512;
    logic          read_i512, resp_o512, resp_i512, read_o512, write_o512;
    logic [BW-1:0] burst_i512, burst_o512;

`ifdef CACHELINE_BURST_PERF_EN
    logic [31:0] perf_fills, perf_wbs, perf_stall;
    logic [31:0] perf_fills512, perf_wbs512, perf_stall512;
`endif

    always #5 clk = ~clk;

    cacheline_burst_adaptor #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .line_i       (line_i),
        .line_o       (line_o),
        .address_i    (address_i),
        .wb_address_i (wb_address_i),
        .read_i       (read_i),
        .write_i      (write_i),
        .resp_o       (resp_o),
        .resp_i       (resp_i),
        .burst_i      (burst_i),
        .burst_o      (burst_o),
        .address_o    (address_o),
        .read_o       (read_o),
        .write_o      (write_o)
`ifdef CACHELINE_BURST_PERF_EN
        ,
        .perf_fills_o (perf_fills),
        .perf_wbs_o   (perf_wbs),
        .perf_stall_o (perf_stall)
`endif
    );

    cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(BW), .ADDR_W(AW)) dut512 (
        .clk          (clk),
        .reset        (reset),
        .line_i       ({512{1'b0}}),
        .line_o       (line_o512),
        .address_i    (address_i512),
        .wb_address_i ({AW{1'b0}}),
        .read_i       (read_i512),
        .write_i      (1'b0),
        .resp_o       (resp_o512),
        .resp_i       (resp_i512),
        .burst_i      (burst_i512),
        .burst_o      (burst_o512),
        .address_o    (address_o512),
        .read_o       (read_o512),
        .write_o      (write_o512)
`ifdef CACHELINE_BURST_PERF_EN
        ,
        .perf_fills_o (perf_fills512),
        .perf_wbs_o   (perf_wbs512),
        .perf_stall_o (perf_stall512)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s", nm, why);
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
    } wexp_t;

    wexp_t         exp_wr[$];
    logic [31:0]   exp_rd[$];
    logic [255:0]  exp_resp[$];

    // Memory model for the main instance.
    int          gap       = 0;
    int          wait_cnt  = 0;
    int          stall_cnt = 0;
    int          rd_idx    = 0;
    logic [63:0] rd_beats[4];

    initial begin
        resp_i  = 1'b0;
        burst_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((read_o || write_o) && !reset) begin
                if (wait_cnt < gap) begin
                    resp_i = 1'b0;
                    wait_cnt++;
                    stall_cnt++;
                end else begin
                    resp_i   = 1'b1;
                    wait_cnt = 0;
                    if (read_o) begin
                        burst_i = rd_beats[rd_idx % 4];
                        rd_idx++;
                    end
                end
            end else begin
                resp_i   = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor for the main instance.
    int idle_run = 0;
    int rd_cyc   = 0;
    int wr_cyc   = 0;
    bit saw_wr   = 1'b0;
    bit prev_rd  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                saw_wr   = 1'b0;
                prev_rd  = 1'b0;
                idle_run = 0;
            end else begin
                if (write_o) begin
                    wr_cyc++;
                    saw_wr = 1'b1;
                    if (exp_wr.size() == 0) begin
                        fail_now("unexpected_wr", "write_o high with no expected beat");
                    end else begin
                        chk("wr_addr", address_o, exp_wr[0].a);
                        chk("wr_data", burst_o, exp_wr[0].d);
                        if (resp_i) void'(exp_wr.pop_front());
                    end
                end
                if (read_o) begin
                    rd_cyc++;
                    if (!prev_rd && saw_wr) chk("gap_cycles", idle_run, 1);
                    if (exp_rd.size() == 0) begin
                        fail_now("unexpected_rd", "read_o high with no expected beat");
                    end else begin
                        chk("rd_addr", address_o, exp_rd[0]);
                        if (resp_i) void'(exp_rd.pop_front());
                    end
                end
                if (resp_o) begin
                    saw_wr = 1'b0;
                    if (exp_resp.size() == 0) begin
                        fail_now("unexpected_resp", "resp_o high with no request pending");
                    end else begin
                        chk("line_o", line_o, exp_resp.pop_front());
                    end
                end
                if (read_o || write_o) idle_run = 0;
                else idle_run++;
                prev_rd = read_o;
            end
        end
    end

    // Memory model and monitor for the 512-bit instance (acks always high).
    int b512_cnt = 0;
    int n_resp512 = 0;
    int idx512 = 0;
    logic [511:0] exp512;

    initial begin
        resp_i512  = 1'b1;
        burst_i512 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (read_o512) begin
                burst_i512 = 64'h0101_0101_0101_0101 * 64'(idx512 + 1);
                idx512++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (read_o512) begin
                    chk("w512_addr", address_o512, 32'h0000_01C0);
                    if (resp_i512) b512_cnt++;
                end
                if (write_o512) fail_now("w512_unexpected_wr", "write_o high on a read-only run");
                if (resp_o512) begin
                    n_resp512++;
                    chk("w512_beats", b512_cnt, 8);
                    chk("w512_line", line_o512, exp512);
                end
            end
        end
    end

    task automatic wait_resp(input string nm);
        bit got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (resp_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now(nm, "resp_o never arrived within 300 cycles");
    endtask

    // Issue one LLC request, scramble inputs once accepted, drop at the resp_o edge.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wba, input logic [255:0] ln, input string nm);
        @(posedge clk);
        #1;
        read_i = rd; write_i = wr; address_i = a; wb_address_i = wba; line_i = ln;
        @(posedge clk);
        #1;
        address_i = ~a; wb_address_i = ~wba; line_i = ~ln;
        wait_resp(nm);
        @(posedge clk);
        #1;
        read_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic exp_read4(input logic [31:0] a);
        for (int k = 0; k < 4; k++) exp_rd.push_back(a);
    endtask

    localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WL = {64'hAAAA_AAAA_AAAA_AAA3, 64'hBBBB_BBBB_BBBB_BBB2,
                                   64'hAAAA_AAAA_AAAA_AAA1, 64'hBBBB_BBBB_BBBB_BBB0};
    localparam logic [255:0] CL = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
                                   64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
    localparam logic [255:0] L3 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                   64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    localparam logic [255:0] L3B = {64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                                    64'hEEEE_EEEE_EEEE_EEEE, 64'hDDDD_DDDD_DDDD_DDDD};
    localparam logic [255:0] L4 = {64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB,
                                   64'hAAAA_AAAA_AAAA_AAAA, 64'h9999_9999_9999_9999};

    initial begin
        reset = 1'b1;
        read_i = 1'b0; write_i = 1'b0; address_i = '0; wb_address_i = '0; line_i = '0;
        read_i512 = 1'b0; address_i512 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_resp_o", resp_o, 1'b0);
        chk("rst_address_o", address_o, 32'h0);
        chk("rst_burst_o", burst_o, 64'h0);
        chk("rst_line_o", line_o, 256'h0);
        @(negedge clk);
        reset = 1'b0;

        // Plain fill, continuous acks.
        gap = 0; rd_idx = 0;
        rd_beats[0] = 64'h1111_1111_1111_1111; rd_beats[1] = 64'h2222_2222_2222_2222;
        rd_beats[2] = 64'h3333_3333_3333_3333; rd_beats[3] = 64'h4444_4444_4444_4444;
        exp_read4(32'h0000_1220);
        exp_resp.push_back(L1);
        rd_cyc = 0;
        do_req(1'b0 | 1'b1, 1'b0, 32'h0000_1234, 32'h0, 256'h0, "t1_resp");
        chk("t1_read_cycles", rd_cyc, 4);

        // Plain write-back with two idle cycles before every ack; line_o keeps L1.
        gap = 2;
        exp_wr.push_back('{a: 32'h0000_4560, d: 64'hBBBB_BBBB_BBBB_BBB0});
        exp_wr.push_back('{a: 32'h0000_4560, d: 64'hAAAA_AAAA_AAAA_AAA1});
        exp_wr.push_back('{a: 32'h0000_4560, d: 64'hBBBB_BBBB_BBBB_BBB2});
        exp_wr.push_back('{a: 32'h0000_4560, d: 64'hAAAA_AAAA_AAAA_AAA3});
        exp_resp.push_back(L1);
        wr_cyc = 0;
        do_req(1'b0, 1'b1, 32'h0000_4567, 32'hDEAD_BEEF, WL, "t2_resp");
        chk("t2_write_cycles", wr_cyc, 12);

        // Evict-then-fill: 4 writes to 0x100, one gap cycle, 4 reads from 0x200.
        gap = 0; rd_idx = 0;
        rd_beats[0] = 64'h5555_5555_5555_5555; rd_beats[1] = 64'h6666_6666_6666_6666;
        rd_beats[2] = 64'h7777_7777_7777_7777; rd_beats[3] = 64'h8888_8888_8888_8888;
        exp_wr.push_back('{a: 32'h0000_0100, d: 64'hC0DE_0000_0000_0000});
        exp_wr.push_back('{a: 32'h0000_0100, d: 64'hC0DE_0000_0000_0001});
        exp_wr.push_back('{a: 32'h0000_0100, d: 64'hC0DE_0000_0000_0002});
        exp_wr.push_back('{a: 32'h0000_0100, d: 64'hC0DE_0000_0000_0003});
        exp_read4(32'h0000_0200);
        exp_resp.push_back(L3);
        rd_cyc = 0; wr_cyc = 0;
        do_req(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0100, CL, "t3_resp");
        chk("t3_write_cycles", wr_cyc, 4);
        chk("t3_read_cycles", rd_cyc, 4);

        // Fill with one idle cycle before each ack, unaligned address.
        gap = 1; rd_idx = 0;
        rd_beats[0] = 64'hDDDD_DDDD_DDDD_DDDD; rd_beats[1] = 64'hEEEE_EEEE_EEEE_EEEE;
        rd_beats[2] = 64'hFFFF_FFFF_FFFF_FFFF; rd_beats[3] = 64'h0123_4567_89AB_CDEF;
        exp_read4(32'h0000_0300);
        exp_resp.push_back(L3B);
        rd_cyc = 0;
        do_req(1'b1, 1'b0, 32'h0000_031F, 32'h0, 256'h0, "t3b_resp");
        chk("t3b_read_cycles", rd_cyc, 8);
`ifdef CACHELINE_BURST_PERF_EN
        chk("perf_fills", perf_fills, 32'd3);
        chk("perf_wbs", perf_wbs, 32'd2);
        chk("perf_stall", perf_stall, 32'd12);
`endif

        // Reset in the middle of a fill: strobes drop at once, no response.
        gap = 0; rd_idx = 0;
        exp_read4(32'h0000_0080);
        @(posedge clk);
        #1;
        read_i = 1'b1; address_i = 32'h0000_0080;
        begin
            int acks = 0;
            for (int n = 0; n < 50 && acks < 2; n++) begin
                @(negedge clk);
                if (read_o && resp_i) acks++;
            end
            if (acks < 2) fail_now("t4_acks", "fewer than 2 read beats acked within 50 cycles");
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_read_o_abort", read_o, 1'b0);
        chk("t4_resp_o_abort", resp_o, 1'b0);
        chk("t4_address_o_abort", address_o, 32'h0);
        exp_rd.delete();
        read_i = 1'b0; rd_idx = 0; stall_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_line_o_reset", line_o, 256'h0);
`ifdef CACHELINE_BURST_PERF_EN
        chk("perf_fills_rst", perf_fills, 32'd0);
        chk("perf_wbs_rst", perf_wbs, 32'd0);
        chk("perf_stall_rst", perf_stall, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Fresh fill after the abort starts from beat 0.
        rd_idx = 0;
        rd_beats[0] = 64'h9999_9999_9999_9999; rd_beats[1] = 64'hAAAA_AAAA_AAAA_AAAA;
        rd_beats[2] = 64'hBBBB_BBBB_BBBB_BBBB; rd_beats[3] = 64'hCCCC_CCCC_CCCC_CCCC;
        exp_read4(32'h0000_0040);
        exp_resp.push_back(L4);
        rd_cyc = 0;
        do_req(1'b1, 1'b0, 32'h0000_0047, 32'h0, 256'h0, "t4b_resp");
        chk("t4b_read_cycles", rd_cyc, 4);

        // 512-bit line: 8 beats, 64-byte alignment.
        exp512 = {64'h0808_0808_0808_0808, 64'h0707_0707_0707_0707,
                  64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505,
                  64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                  64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        idx512 = 0; b512_cnt = 0;
        @(posedge clk);
        #1;
        read_i512 = 1'b1; address_i512 = 32'h0000_01FF;
        begin
            bit got = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (resp_o512) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) fail_now("w512_resp", "resp_o never arrived within 100 cycles");
        end
        @(posedge clk);
        #1;
        read_i512 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("w512_resp_count", n_resp512, 1);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
